// File: rtl/grf_commit_pkg.sv
// Shared constants and types for the commit register file and its trace queue.
package grf_commit_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] word_t;

  // One retired write-back as seen by the trace monitor.
  typedef struct packed {
    word_t     pc;
    reg_addr_t addr;
    word_t     data;
  } trace_entry_t;

  // A write-back only counts as a commit when it targets a real register.
  function automatic logic is_commit(input logic we, input reg_addr_t wa);
    return we && (wa != reg_addr_t'(REG_ZERO));
  endfunction

endpackage

// File: rtl/grf_commit_if.sv
// Write-back, decode-read and commit-trace signals of grf_commit.
interface grf_commit_if import grf_commit_pkg::*; #(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          we;
  reg_addr_t     wa;
  word_t         wd;
  word_t         w_pc;
  reg_addr_t     ra1;
  reg_addr_t     ra2;
  word_t         rd1;
  word_t         rd2;
  logic          trace_valid;
  logic          trace_ready;
  word_t         trace_pc;
  reg_addr_t     trace_addr;
  word_t         trace_data;
  logic [CW-1:0] trace_count;
  logic          trace_overflow;

  modport master (
    output we, wa, wd, w_pc, ra1, ra2, trace_ready,
    input  rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, trace_overflow
  );

  modport slave (
    input  we, wa, wd, w_pc, ra1, ra2, trace_ready,
    output rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, trace_overflow
  );

endinterface

// File: rtl/grf_commit_fifo.sv
// Commit-trace queue: push, valid/ready pop, occupancy count, sticky overflow.
module commit_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_ready_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, push_ok;

  // Next-state: a pop frees a slot in the same cycle, so push+pop when full is accepted.
  always_comb begin
    full     = (count_q == FULL_COUNT);
    pop      = (count_q != '0) && pop_ready_i;
    push_ok  = push_i && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_i && !push_ok) ovf_d = 1'b1;
  end

  // Pointer, occupancy and overflow state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o    = (count_q != '0);
  assign head_o     = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/grf_commit.sv
// 32x32 general register file with same-cycle write-back bypass and a commit trace queue.
module grf_commit import grf_commit_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  grf_commit_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  word_t         regs_q [NUM_REGS];
  logic          commit;
  word_t         rd1, rd2;
  trace_entry_t  push_entry, head;
  logic [CW-1:0] count;
  logic          valid, overflow;

  assign commit     = is_commit(bus.we, bus.wa);
  assign push_entry = '{pc: bus.w_pc, addr: bus.wa, data: bus.wd};

  // Register write on commit; $0 is never a commit target so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[bus.wa] <= bus.wd;
    end
  end

  // Decode reads: $0 forced to zero, otherwise the in-flight write-back wins over the array.
  always_comb begin
    rd1 = regs_q[bus.ra1];
    rd2 = regs_q[bus.ra2];
    if (bus.we && (bus.wa == bus.ra1)) rd1 = bus.wd;
    if (bus.we && (bus.wa == bus.ra2)) rd2 = bus.wd;
    if (bus.ra1 == reg_addr_t'(REG_ZERO)) rd1 = '0;
    if (bus.ra2 == reg_addr_t'(REG_ZERO)) rd2 = '0;
  end

  commit_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (commit),
    .push_data_i (push_entry),
    .pop_ready_i (bus.trace_ready),
    .valid_o     (valid),
    .head_o      (head),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  assign bus.rd1            = rd1;
  assign bus.rd2            = rd2;
  assign bus.trace_valid    = valid;
  assign bus.trace_pc       = head.pc;
  assign bus.trace_addr     = head.addr;
  assign bus.trace_data     = head.data;
  assign bus.trace_count    = count;
  assign bus.trace_overflow = overflow;

endmodule

// File: tb/tb_grf_commit.sv
// Randomized and directed bench for grf_commit against a queue-based reference model.
module tb_grf_commit;
  import grf_commit_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  grf_commit_if #(.DEPTH(DEPTH)) bus ();

  grf_commit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  word_t        m_regs [NUM_REGS];
  trace_entry_t m_q [$];
  logic         m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic word_t m_read(input reg_addr_t ra);
    if (ra == 0) return '0;
    if (bus.we && bus.wa == ra) return bus.wd;
    return m_regs[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_REGS); i++) m_regs[i] = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    trace_entry_t e;
    bit pop, cmt;
    pop = (m_q.size() != 0) && bus.trace_ready;
    cmt = bus.we && (bus.wa != 0);
    if (pop) void'(m_q.pop_front());
    if (cmt) begin
      m_regs[bus.wa] = bus.wd;
      e = '{pc: bus.w_pc, addr: bus.wa, data: bus.wd};
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    trace_entry_t h;
    h = (m_q.size() != 0) ? m_q[0] : '0;
    check_eq("rd1", bus.rd1, m_read(bus.ra1));
    check_eq("rd2", bus.rd2, m_read(bus.ra2));
    check_eq("trace_valid", 32'(bus.trace_valid), 32'(m_q.size() != 0));
    check_eq("trace_count", 32'(bus.trace_count), m_q.size());
    check_eq("trace_overflow", 32'(bus.trace_overflow), 32'(m_ovf));
    check_eq("trace_pc", bus.trace_pc, h.pc);
    check_eq("trace_addr", 32'(bus.trace_addr), 32'(h.addr));
    check_eq("trace_data", bus.trace_data, h.data);
  endtask

  // Called 1 time unit after a rising edge: check mid-cycle, then advance one edge.
  task automatic tick();
    #3;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic we, input reg_addr_t wa, input word_t wd, input word_t pc,
                       input reg_addr_t ra1, input reg_addr_t ra2, input logic rdy);
    bus.we          = we;
    bus.wa          = wa;
    bus.wd          = wd;
    bus.w_pc        = pc;
    bus.ra1         = ra1;
    bus.ra2         = ra2;
    bus.trace_ready = rdy;
  endtask

  // Reset pulse strictly between edges; outputs must clear without a clock.
  task automatic async_reset(input reg_addr_t ra);
    drive(1'b0, 5'd0, '0, '0, ra, 5'd0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("ar_valid", 32'(bus.trace_valid), 32'd0);
    check_eq("ar_count", 32'(bus.trace_count), 32'd0);
    check_eq("ar_overflow", 32'(bus.trace_overflow), 32'd0);
    check_eq("ar_rd1", bus.rd1, 32'd0);
    check_all();
    #1;
    reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    reg_addr_t wa, ra1, ra2;
    logic      we, rdy;

    reset = 1'b1;
    drive(1'b0, 5'd0, '0, '0, 5'd7, 5'd31, 1'b0);
    model_reset();
    #2;
    check_all();
    check_eq("rst_count", 32'(bus.trace_count), 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset held across an edge ignores write enable and ready.
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 32'h10, 5'd3, 5'd0, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, '0, '0, 5'd3, 5'd0, 1'b0);
    #1;
    check_eq("rsthold_rd1", bus.rd1, 32'd0);
    check_eq("rsthold_count", 32'(bus.trace_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Same-cycle bypass, then the registered value.
    drive(1'b1, 5'd5, 32'h1234, 32'h100, 5'd5, 5'd0, 1'b0);
    #2;
    check_eq("byp_rd1", bus.rd1, 32'h1234);
    check_eq("byp_rd2", bus.rd2, 32'd0);
    tick();
    drive(1'b0, 5'd0, '0, '0, 5'd5, 5'd5, 1'b0);
    #2;
    check_eq("byp_next_rd1", bus.rd1, 32'h1234);
    tick();

    // Write to $0 is neither stored nor traced.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h200, 5'd0, 5'd0, 1'b0);
    #2;
    check_eq("z_rd1", bus.rd1, 32'd0);
    tick();
    drive(1'b0, 5'd0, '0, '0, 5'd0, 5'd5, 1'b0);
    #2;
    check_eq("z_count", 32'(bus.trace_count), 32'd1);
    tick();

    // Drain, then strict FIFO order.
    drive(1'b0, 5'd0, '0, '0, 5'd0, 5'd0, 1'b1);
    tick();
    drive(1'b1, 5'd1, 32'hA, 32'h3000, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 5'd2, 32'hB, 32'h3004, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b0, 5'd0, '0, '0, 5'd1, 5'd2, 1'b1);
    #2;
    check_eq("ord_count2", 32'(bus.trace_count), 32'd2);
    check_eq("ord_addr1", 32'(bus.trace_addr), 32'd1);
    check_eq("ord_data1", bus.trace_data, 32'hA);
    check_eq("ord_pc1", bus.trace_pc, 32'h3000);
    tick();
    #2;
    check_eq("ord_count1", 32'(bus.trace_count), 32'd1);
    check_eq("ord_addr2", 32'(bus.trace_addr), 32'd2);
    check_eq("ord_data2", bus.trace_data, 32'hB);
    tick();
    #2;
    check_eq("ord_count0", 32'(bus.trace_count), 32'd0);
    check_eq("ord_valid0", 32'(bus.trace_valid), 32'd0);
    tick();

    // Overflow: five commits into a four-entry queue with no pops.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, reg_addr_t'(10 + i), word_t'(i + 1), word_t'(32'h4000 + 4 * i), 5'd10, 5'd14, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, '0, '0, 5'd10, 5'd14, 1'b0);
    #2;
    check_eq("ovf_count", 32'(bus.trace_count), 32'd4);
    check_eq("ovf_flag", 32'(bus.trace_overflow), 32'd1);
    check_eq("ovf_head_pc", bus.trace_pc, 32'h4000);
    tick();
    drive(1'b1, 5'd20, 32'hBEEF, 32'h5000, 5'd20, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, '0, '0, 5'd20, 5'd0, 1'b0);
    #2;
    check_eq("full_pp_count", 32'(bus.trace_count), 32'd4);
    check_eq("full_pp_head", bus.trace_pc, 32'h4004);
    tick();
    drive(1'b0, 5'd0, '0, '0, 5'd20, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    #2;
    check_eq("full_pp_tail_pc", bus.trace_pc, 32'h5000);
    check_eq("full_pp_tail_data", bus.trace_data, 32'hBEEF);
    tick();

    // Asynchronous reset with three queued entries and reg[7]=0x55.
    drive(1'b1, 5'd7, 32'h55, 32'h6000, 5'd7, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd8, 32'h66, 32'h6004, 5'd7, 5'd8, 1'b0);
    tick();
    drive(1'b1, 5'd9, 32'h77, 32'h6008, 5'd7, 5'd9, 1'b0);
    tick();
    drive(1'b0, 5'd0, '0, '0, 5'd7, 5'd0, 1'b0);
    #2;
    check_eq("ar_pre_rd1", bus.rd1, 32'h55);
    check_eq("ar_pre_count", 32'(bus.trace_count), 32'd3);
    tick();
    async_reset(5'd7);

    // Random traffic; pop rate changes halfway to exercise both full and empty.
    for (int n = 0; n < 600; n++) begin
      we  = ($urandom_range(0, 9) < 7);
      wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : reg_addr_t'($urandom_range(1, 31));
      ra1 = ($urandom_range(0, 2) == 0) ? wa : reg_addr_t'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : reg_addr_t'($urandom_range(0, 31));
      rdy = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(we, wa, word_t'($urandom), word_t'($urandom), ra1, ra2, rdy);
      tick();
      if (n == 450) async_reset(reg_addr_t'($urandom_range(0, 31)));
    end

    drive(1'b0, 5'd0, '0, '0, 5'd0, 5'd0, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
